// File: rtl/warmboot_seq_pkg.sv
// ----------------------------------------------------------------------------
// warmboot_seq_pkg: shared types and reset values for warmboot_sequencer. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package warmboot_seq_pkg;

  localparam int SLOT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    PULSE = 2'd2,
    WAIT  = 2'd3
  } state_t;

  localparam state_t            STATE_RST = IDLE;
  localparam logic [SLOT_W-1:0] SLOT_RST  = '0;
  localparam logic              BOOT_RST  = 1'b0;
  localparam logic              ERR_RST   = 1'b0;

  // Counter width for a count of n; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/req_debounce.sv
// ----------------------------------------------------------------------------
// req_debounce: 2-flop synchronizer, stable-count debouncer, rising-edge pulse. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module req_debounce
  import warmboot_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic RESET,
  input  logic req_in,
  output logic req_event
);

  localparam int           CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (RESET) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      level     <= 1'b0;
      cnt       <= '0;
      req_event <= 1'b0;
    end else begin
      sync1     <= req_in;
      sync2     <= sync1;
      req_event <= 1'b0;
      // Any sample agreeing with the current level restarts the stability run.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt       <= '0;
        level     <= sync2;
        req_event <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/warmboot_sequencer.sv
// ----------------------------------------------------------------------------
// warmboot_sequencer: request -> slot setup, BOOT pulse, supervised wait. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module warmboot_sequencer
  import warmboot_seq_pkg::*;
#(
  parameter int NUM_SLOTS       = 16,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int SETUP_CYCLES    = 4,
  parameter int PULSE_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES  = 65535
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              req_in,
  input  logic [SLOT_W-1:0] slot_in,
  input  logic              auto_en,
  output logic [SLOT_W-1:0] slot_out,
  output logic              boot_out,
  output logic              busy,
  output logic              err,
  output logic [1:0]        state_out
);

  localparam int MAX_AB    = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int MAX_CYC   = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
  localparam int CW        = cnt_width(MAX_CYC);

  localparam logic [CW-1:0]     SETUP_LAST   = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0]     PULSE_LAST   = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0]     TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [SLOT_W-1:0] LAST_RST     = SLOT_W'(NUM_SLOTS - 1);
  localparam logic [SLOT_W:0]   NUM_SLOTS_W  = (SLOT_W + 1)'(NUM_SLOTS);

  state_t            state, state_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic [SLOT_W-1:0] last_slot, last_d, slot_d, slot_sel;
  logic              err_d, boot_d, slot_ok, req_event;

  req_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_req_debounce (
    .clk       (clk),
    .RESET     (RESET),
    .req_in    (req_in),
    .req_event (req_event)
  );

  // last_slot is always in range, so round-robin never yields an invalid slot.
  always_comb begin
    slot_sel = slot_in;
    slot_ok  = ({1'b0, slot_in} < NUM_SLOTS_W);
    if (auto_en) begin
      slot_sel = (last_slot == LAST_RST) ? '0 : last_slot + SLOT_W'(1);
      slot_ok  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state <= STATE_RST;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt + CW'(1);
    slot_d  = slot_out;
    last_d  = last_slot;
    err_d   = err;
    boot_d  = 1'b0;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (req_event) begin
          if (slot_ok) begin
            state_d = ARM;
            slot_d  = slot_sel;
            last_d  = slot_sel;
            err_d   = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ARM: begin
        if (cnt == SETUP_LAST) begin
          state_d = PULSE;
          cnt_d   = '0;
          boot_d  = 1'b1;
        end
      end
      PULSE: begin
        boot_d = 1'b1;
        if (cnt == PULSE_LAST) begin
          state_d = WAIT;
          cnt_d   = '0;
          boot_d  = 1'b0;
        end
      end
      WAIT: begin
        if (cnt == TIMEOUT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          err_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      cnt       <= '0;
      slot_out  <= SLOT_RST;
      last_slot <= LAST_RST;
      err       <= ERR_RST;
      boot_out  <= BOOT_RST;
    end else begin
      cnt       <= cnt_d;
      slot_out  <= slot_d;
      last_slot <= last_d;
      err       <= err_d;
      boot_out  <= boot_d;
    end
  end

  assign busy      = (state != IDLE);
  assign state_out = state;

endmodule

`default_nettype wire

// File: doc/warmboot_sequencer.md
# warmboot_sequencer

Sequencer for the fabric's warm-boot primitive. It turns a noisy user request plus a requested slot number into a clean, correctly timed SLOT/BOOT sequence for `WARMBOOT_wrapper`: slot setup first, then a fixed-width BOOT pulse, then a supervised wait. It sits inside a user design between the IO pins and the `WARMBOOT_wrapper` instance, and optionally steps through slots round-robin.

## Interface

Parameters:
- `NUM_SLOTS`, 16: number of valid bitstream slots, 1..16. Slot field is fixed at 4 bits.
- `DEBOUNCE_CYCLES`, 1000: consecutive stable samples required before the request level changes.
- `SETUP_CYCLES`, 4: cycles SLOT is stable before BOOT rises, ≥1.
- `PULSE_CYCLES`, 8: BOOT high time in cycles, ≥1.
- `TIMEOUT_CYCLES`, 65535: cycles to wait after the pulse before declaring failure, ≥1.

Ports:
- `clk`  in  1: single clock. Everything is in this domain.
- `RESET`  in  1: synchronous, active-high. Driven from `WARMBOOT_wrapper` RESET.
- `req_in`  in  1: raw asynchronous boot request (button/pin).
- `slot_in`  in  4: requested slot, sampled on request acceptance.
- `auto_en`  in  1: 1 selects round-robin slot, 0 selects `slot_in`.
- `slot_out`  out  4: to `WARMBOOT_wrapper.SLOT`.
- `boot_out`  out  1: to `WARMBOOT_wrapper.BOOT`.
- `busy`  out  1: high in any state other than IDLE.
- `err`  out  1: sticky error, either an invalid slot or a timeout.
- `state_out`  out  2: current state encoding, for debug pins.

## Operation

- **Request path.** `req_in` passes through a 2-flop synchronizer, then the debouncer. The debounced level changes only after `DEBOUNCE_CYCLES` consecutive samples that differ from it. A rising edge of the debounced level is the request event. Holding the request produces exactly one event.
- **Slot choice at event.**
  - With `auto_en`=1, slot = (`last_slot`+1) mod `NUM_SLOTS`.
  - With `auto_en`=0, slot = `slot_in`.
  - `last_slot` resets to `NUM_SLOTS`-1, so the first auto boot selects slot 0.
- **FSM states.** IDLE=0, ARM=1, PULSE=2, WAIT=3.
  - IDLE: on an event with a valid slot (< `NUM_SLOTS`), latch the slot into `slot_out` and `last_slot`, clear `err`, then go to ARM. On an event with an invalid slot, set `err` and stay in IDLE; `slot_out` is unchanged.
  - ARM: count `SETUP_CYCLES`, then go to PULSE.
  - PULSE: `boot_out`=1 for `PULSE_CYCLES`, then go to WAIT.
  - WAIT: count `TIMEOUT_CYCLES`. On expiry set `err` and go to IDLE. A successful reconfiguration replaces the design, so normal completion never returns here.
- **Events while busy.** Events occurring outside IDLE are dropped and not queued. `slot_in` and `auto_en` are ignored outside IDLE.
- **Reset.** `RESET` overrides everything, including mid-PULSE. One edge later: state IDLE, `boot_out`=0, `slot_out`=0, `busy`=0, `err`=0, all counters 0, debounced level 0, `last_slot`=`NUM_SLOTS`-1.

## Timing

- **Debounce latency.** A clean `req_in` rise is seen as an event 2 (sync) + `DEBOUNCE_CYCLES` edges later.
- **Entering ARM.** On the event cycle, the FSM registers ARM and `slot_out` on the next edge. `busy` rises in the same cycle as `slot_out` updates.
- **Setup.** `slot_out` is stable for exactly `SETUP_CYCLES` cycles before the first cycle with `boot_out`=1.
- **Pulse.** `boot_out` is registered, glitch-free, and high for exactly `PULSE_CYCLES` consecutive cycles.
- **Slot hold.** `slot_out` is held constant through ARM, PULSE and WAIT.
- **Timeout.** `err` and the IDLE transition occur on the same edge, `TIMEOUT_CYCLES` cycles after `boot_out` falls.
- **Counter width.** Counters are sized with $clog2 of their parameter. Each counter clears on state entry. There is no wrap inside a state.
- **Simultaneous event.** If an event coincides with `RESET`, reset wins and the event is lost.

## Structure

- **Package `warmboot_seq_pkg`:**
  - state enum (IDLE/ARM/PULSE/WAIT, 2-bit);
  - `SLOT_W`=4;
  - reset value constants.
- **Sub-module `req_debounce`:** synchronizer, stable-count debouncer and rising-edge output, parameterised by `DEBOUNCE_CYCLES`. Instantiated once.
- **Top level:** the FSM, slot selection and the counters.

## Test plan

Use `DEBOUNCE_CYCLES`=4, `SETUP_CYCLES`=2, `PULSE_CYCLES`=3, `TIMEOUT_CYCLES`=10 unless stated.

1. **Clean request.** `slot_in`=5, `auto_en`=0, `req_in` held high → event at edge 6. `slot_out`=5 and `busy`=1 at edge 7, `boot_out` high for edges 9–11, WAIT 10 cycles, then `err`=1 and IDLE.
2. **Bounce.** `req_in` toggles every 2 cycles for 20 cycles, then is held high → exactly one event, 4 stable cycles after the final rise. No event occurs during the toggling.
3. **Invalid slot.** `NUM_SLOTS`=8, `slot_in`=9 → `err`=1 one cycle after the event. `busy` stays 0, `boot_out` never asserts, `slot_out` stays 0.
4. **Auto rotate.** `auto_en`=1, `NUM_SLOTS`=3, four requests each completed by timeout → `slot_out` sequence 0,1,2,0.
5. **Reset mid-pulse.** `RESET` asserted on the 2nd PULSE cycle → next edge `boot_out`=0, `slot_out`=0, `state_out`=0. A subsequent request runs the full sequence normally.
6. **Request while busy.** A second debounced event during WAIT is ignored. `slot_out` is unchanged and no second pulse occurs.
